// File: rtl/fib_pkg.sv
// Shared types and default sizing for the Fibonacci request front-end.
package fib_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } state_t;

    localparam int unsigned FIB_NW    = 8;
    localparam int unsigned FIB_RW    = 16;
    localparam int unsigned FIB_MAX_N = 24;

endpackage

// File: rtl/fib_dispatch_if.sv
// Request, core and response handshakes of fib_dispatch; the dispatcher uses the slave modport.
interface fib_dispatch_if
    import fib_pkg::*;
#(
    parameter int unsigned NW = FIB_NW,
    parameter int unsigned RW = FIB_RW
);

    logic          req_valid;
    logic          req_ready;
    logic [NW-1:0] req_n;

    logic          core_start;
    logic [NW-1:0] core_n;
    logic          core_done;
    logic [RW-1:0] core_result;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [NW-1:0] rsp_n;
    logic [RW-1:0] rsp_result;
    logic          rsp_err;

    // Environment side: producer, Fibonacci core and consumer.
    modport master (
        output req_valid, req_n, core_done, core_result, rsp_ready,
        input  req_ready, core_start, core_n, rsp_valid, rsp_n, rsp_result, rsp_err
    );

    modport slave (
        input  req_valid, req_n, core_done, core_result, rsp_ready,
        output req_ready, core_start, core_n, rsp_valid, rsp_n, rsp_result, rsp_err
    );

endinterface

// File: rtl/fib_req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit so full/empty come from an MSB compare.
module fib_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned NW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [NW-1:0] i_data,
    input  logic          i_pop,
    output logic          o_full,
    output logic          o_empty,
    output logic [NW-1:0] o_head
);

    localparam int unsigned AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fib_req_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [NW-1:0] r_mem [DEPTH];
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/fib_dispatch.sv
// Front-end for the Fibonacci core: queues requests, runs them one at a time, returns responses.
// Optional range rejection of n > MAX_N is enabled by defining FIB_DISPATCH_RANGE_CHECK_EN.
module fib_dispatch
    import fib_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned NW    = FIB_NW,
    parameter int unsigned RW    = FIB_RW,
    parameter int unsigned MAX_N = FIB_MAX_N
) (
    input  logic           clk,
    input  logic           rst,
    fib_dispatch_if.slave  io_bus
);

    if (MAX_N >= 2 ** NW) begin : g_bad_max_n
        $error("fib_dispatch: MAX_N does not fit in NW bits");
    end

    state_t        r_state;
    logic          r_core_start;
    logic [NW-1:0] r_core_n;
    logic          r_rsp_valid;
    logic [NW-1:0] r_rsp_n;
    logic [RW-1:0] r_rsp_result;

    logic          w_full;
    logic          w_empty;
    logic [NW-1:0] w_head;
    logic          w_push;
    logic          w_pop;

    // No bypass: a full FIFO refuses pushes even if the head pops this cycle.
    assign w_push = io_bus.req_valid && !w_full;
    assign w_pop  = (r_state == StResp) && io_bus.rsp_ready;

    fib_req_fifo #(
        .DEPTH (DEPTH),
        .NW    (NW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (io_bus.req_n),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

`ifdef FIB_DISPATCH_RANGE_CHECK_EN
    localparam logic [NW-1:0] MaxN = NW'(MAX_N);
    logic r_rsp_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_core_start <= 1'b0;
            r_core_n     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_n      <= '0;
            r_rsp_result <= '0;
`ifdef FIB_DISPATCH_RANGE_CHECK_EN
            r_rsp_err    <= 1'b0;
`endif
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (!w_empty) begin
`ifdef FIB_DISPATCH_RANGE_CHECK_EN
                        if (w_head > MaxN) begin
                            r_state      <= StResp;
                            r_rsp_valid  <= 1'b1;
                            r_rsp_n      <= w_head;
                            r_rsp_result <= '0;
                            r_rsp_err    <= 1'b1;
                        end else
`endif
                        begin
                            r_state      <= StIssue;
                            r_core_start <= 1'b1;
                            r_core_n     <= w_head;
                        end
                    end
                end
                StIssue: r_state <= StWait;
                StWait: begin
                    if (io_bus.core_done) begin
                        r_state      <= StResp;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_n      <= r_core_n;
                        r_rsp_result <= io_bus.core_result;
`ifdef FIB_DISPATCH_RANGE_CHECK_EN
                        r_rsp_err    <= 1'b0;
`endif
                    end
                end
                StResp: begin
                    if (io_bus.rsp_ready) begin
                        r_state     <= StIdle;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.req_ready  = !w_full;
    assign io_bus.core_start = r_core_start;
    assign io_bus.core_n     = r_core_n;
    assign io_bus.rsp_valid  = r_rsp_valid;
    assign io_bus.rsp_n      = r_rsp_n;
    assign io_bus.rsp_result = r_rsp_result;
`ifdef FIB_DISPATCH_RANGE_CHECK_EN
    assign io_bus.rsp_err    = r_rsp_err;
`else
    assign io_bus.rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fib_dispatch.sv
// Directed self-checking bench for fib_dispatch; the core is modelled by tasks driving core_done.
module tb_fib_dispatch;

    logic clk;
    logic rst;

    fib_dispatch_if bus ();

    fib_dispatch dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Core-side monitor: counts launches and flags overlapping jobs.
    int         start_cnt    = 0;
    int         overlap_err  = 0;
    bit         outstanding  = 1'b0;
    logic [7:0] last_start_n = 8'd0;

    always @(posedge clk) begin
        if (rst) begin
            outstanding <= 1'b0;
        end else if (bus.core_start) begin
            start_cnt    <= start_cnt + 1;
            last_start_n <= bus.core_n;
            if (outstanding) overlap_err <= overlap_err + 1;
            outstanding  <= 1'b1;
        end else if (bus.core_done) begin
            outstanding <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_req(input logic [7:0] n);
        int k = 0;
        bus.req_valid = 1'b1;
        bus.req_n     = n;
        while (!bus.req_ready && k < 100) begin
            tick();
            k++;
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_timeout n=%0d: req_ready got %b want 1", n, bus.req_ready);
        end
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic core_finish(input logic [15:0] res);
        bus.core_done   = 1'b1;
        bus.core_result = res;
        tick();
        bus.core_done   = 1'b0;
        bus.core_result = 16'hdead;
    endtask

    // Waits for the launch of n_exp, answers with res and checks the response next cycle.
    task automatic serve(input logic [7:0] n_exp, input logic [15:0] res);
        int k = 0;
        while (!outstanding && k < 100) begin
            tick();
            k++;
        end
        checks++;
        if (outstanding !== 1'b1) begin
            errors++;
            $display("FAIL serve_start n=%0d: no core_start seen", n_exp);
        end
        checks++;
        if (last_start_n !== n_exp) begin
            errors++;
            $display("FAIL serve_core_n: got %0d want %0d", last_start_n, n_exp);
        end
        tick();
        tick();
        core_finish(res);
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL serve_rsp_valid n=%0d: got %b want 1", n_exp, bus.rsp_valid);
        end
        checks++;
        if (bus.rsp_n !== n_exp) begin
            errors++;
            $display("FAIL serve_rsp_n: got %0d want %0d", bus.rsp_n, n_exp);
        end
        checks++;
        if (bus.rsp_result !== res) begin
            errors++;
            $display("FAIL serve_rsp_result n=%0d: got %0d want %0d", n_exp, bus.rsp_result, res);
        end
        checks++;
        if (bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL serve_rsp_err n=%0d: got %b want 0", n_exp, bus.rsp_err);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        checks++;
        if (bus.core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start: got %b want 0", bus.core_start); end
        checks++;
        if (bus.core_n !== 8'd0) begin errors++; $display("FAIL reset_core_n: got %0d want 0", bus.core_n); end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++;
        if (bus.rsp_n !== 8'd0) begin errors++; $display("FAIL reset_rsp_n: got %0d want 0", bus.rsp_n); end
        checks++;
        if (bus.rsp_result !== 16'd0) begin errors++; $display("FAIL reset_rsp_result: got %0d want 0", bus.rsp_result); end
        checks++;
        if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
    endtask

    task automatic test_single();
        int s0 = start_cnt;
        push_req(8'd10);
        checks++;
        if (bus.core_start !== 1'b0) begin errors++; $display("FAIL single_early_start: got %b want 0", bus.core_start); end
        tick();
        checks++;
        if (bus.core_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", bus.core_start); end
        checks++;
        if (bus.core_n !== 8'd10) begin errors++; $display("FAIL single_core_n: got %0d want 10", bus.core_n); end
        tick();
        checks++;
        if (bus.core_start !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b want 0", bus.core_start); end
        repeat (198) tick();
        checks++;
        if (start_cnt - s0 !== 1) begin errors++; $display("FAIL single_start_count: got %0d want 1", start_cnt - s0); end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp: got %b want 0", bus.rsp_valid); end
        checks++;
        if (bus.core_n !== 8'd10) begin errors++; $display("FAIL single_core_n_hold: got %0d want 10", bus.core_n); end
        core_finish(16'd55);
        checks++;
        if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b want 1", bus.rsp_valid); end
        checks++;
        if (bus.rsp_n !== 8'd10) begin errors++; $display("FAIL single_rsp_n: got %0d want 10", bus.rsp_n); end
        checks++;
        if (bus.rsp_result !== 16'd55) begin errors++; $display("FAIL single_rsp_result: got %0d want 55", bus.rsp_result); end
        checks++;
        if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp_err: got %b want 0", bus.rsp_err); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop: got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ns  [4] = '{8'd0, 8'd1, 8'd2, 8'd20};
        logic [15:0] fib [4] = '{16'd0, 16'd1, 16'd1, 16'd6765};
        int s0 = start_cnt;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_req(ns[i]);
        for (int i = 0; i < 4; i++) serve(ns[i], fib[i]);
        tick();
        bus.rsp_ready = 1'b0;
        checks++;
        if (start_cnt - s0 !== 4) begin errors++; $display("FAIL b2b_start_count: got %0d want 4", start_cnt - s0); end
        checks++;
        if (overlap_err !== 0) begin errors++; $display("FAIL b2b_overlap: got %0d want 0", overlap_err); end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_full();
        logic [7:0]  ns  [5] = '{8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        logic [15:0] fib [5] = '{16'd2, 16'd3, 16'd5, 16'd8, 16'd13};
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_req(ns[i]);
        checks++;
        if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL full_ready_drop: got %b want 0", bus.req_ready); end
        bus.req_valid = 1'b1;
        bus.req_n     = ns[4];
        repeat (3) tick();
        checks++;
        if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL full_ready_held: got %b want 0", bus.req_ready); end
        serve(ns[0], fib[0]);
        checks++;
        if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL full_ready_in_resp: got %b want 0", bus.req_ready); end
        bus.rsp_ready = 1'b1;
        tick();
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL full_ready_return: got %b want 1", bus.req_ready); end
        tick();
        bus.req_valid = 1'b0;
        for (int i = 1; i < 5; i++) serve(ns[i], fib[i]);
        tick();
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL full_ready_end: got %b want 1", bus.req_ready); end
        checks++;
        if (overlap_err !== 0) begin errors++; $display("FAIL full_overlap: got %0d want 0", overlap_err); end
    endtask

    task automatic test_stall();
        int s0;
        bus.rsp_ready = 1'b0;
        push_req(8'd24);
        serve(8'd24, 16'd46368);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_n !== 8'd24 || bus.rsp_result !== 16'd46368) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got valid=%b n=%0d result=%0d want 1/24/46368",
                         i, bus.rsp_valid, bus.rsp_n, bus.rsp_result);
            end
        end
        s0 = start_cnt;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", bus.rsp_valid); end
        push_req(8'd6);
        serve(8'd6, 16'd8);
        checks++;
        if (start_cnt - s0 !== 1) begin errors++; $display("FAIL stall_single_pop: got %0d starts want 1", start_cnt - s0); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int s0;
        push_req(8'd9);
        push_req(8'd11);
        push_req(8'd12);
        tick();
        checks++;
        if (outstanding !== 1'b1 || last_start_n !== 8'd9) begin
            errors++;
            $display("FAIL midrst_wait: got outstanding=%b n=%0d want 1/9", outstanding, last_start_n);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.core_start !== 1'b0 || bus.core_n !== 8'd0) begin
            errors++;
            $display("FAIL midrst_core_side: got ready=%b start=%b core_n=%0d want 1/0/0",
                     bus.req_ready, bus.core_start, bus.core_n);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_n !== 8'd0 || bus.rsp_result !== 16'd0 || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_rsp_side: got valid=%b n=%0d result=%0d err=%b want 0/0/0/0",
                     bus.rsp_valid, bus.rsp_n, bus.rsp_result, bus.rsp_err);
        end
        s0 = start_cnt;
        core_finish(16'd34);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_late_done: got %b want 0", bus.rsp_valid); end
        repeat (6) tick();
        checks++;
        if (start_cnt - s0 !== 0) begin errors++; $display("FAIL midrst_flush: got %0d starts want 0", start_cnt - s0); end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp: got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_range();
        int s0 = start_cnt;
        bus.rsp_ready = 1'b0;
        push_req(8'd25);
`ifdef FIB_DISPATCH_RANGE_CHECK_EN
        begin
            int k = 0;
            while (!bus.rsp_valid && k < 50) begin
                tick();
                k++;
            end
        end
        checks++;
        if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL range_rsp_valid: got %b want 1", bus.rsp_valid); end
        checks++;
        if (bus.rsp_err !== 1'b1) begin errors++; $display("FAIL range_rsp_err: got %b want 1", bus.rsp_err); end
        checks++;
        if (bus.rsp_result !== 16'd0) begin errors++; $display("FAIL range_rsp_result: got %0d want 0", bus.rsp_result); end
        checks++;
        if (bus.rsp_n !== 8'd25) begin errors++; $display("FAIL range_rsp_n: got %0d want 25", bus.rsp_n); end
        checks++;
        if (start_cnt - s0 !== 0) begin errors++; $display("FAIL range_no_start: got %0d starts want 0", start_cnt - s0); end
`else
        // fib(25) = 75025, which the core truncates to 16 bits.
        serve(8'd25, 16'd9489);
        checks++;
        if (start_cnt - s0 !== 1) begin errors++; $display("FAIL range_dispatch: got %0d starts want 1", start_cnt - s0); end
`endif
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL range_pop: got %b want 0", bus.rsp_valid); end
    endtask

    initial begin
        rst             = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_n       = 8'd0;
        bus.core_done   = 1'b0;
        bus.core_result = 16'd0;
        bus.rsp_ready   = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_stall();
        test_reset_mid();
        test_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
